serial_sub_seq: RTL

- Bit-serial subtraction sequencer that drives the team's 1-bit full-subtractor cell.
- It latches two WIDTH-bit operands and presents one bit pair per cycle, LSB first, to the cell's A/B/Bin inputs.
- Each cycle it captures the cell's D/Bout outputs, feeds the captured borrow back as the next Bin, and assembles the difference.
- It sits both upstream (operand feed) and downstream (result capture) of the cell; the cell stays outside this module.

---
 rtl/serial_sub_seq_if.sv | 53 +++++
 rtl/serial_sub_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_sub_seq_if.sv
// Bundle of request, result and full-subtractor cell signals for serial_sub_seq.
// The slave modport is the sequencer's view; master is the requester plus the external cell.
interface serial_sub_seq_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             fs_a;
   logic             fs_b;
   logic             fs_bin;
   logic             fs_d;
   logic             fs_bout;

   modport slave (
      input  start,
      input  a,
      input  b,
      input  bin,
      input  fs_d,
      input  fs_bout,
      output busy,
      output done,
      output diff,
      output borrow_out,
      output fs_a,
      output fs_b,
      output fs_bin
   );

   modport master (
      output start,
      output a,
      output b,
      output bin,
      output fs_d,
      output fs_bout,
      input  busy,
      input  done,
      input  diff,
      input  borrow_out,
      input  fs_a,
      input  fs_b,
      input  fs_bin
   );

endinterface

// File: rtl/serial_sub_seq.sv
// Bit-serial subtraction sequencer: feeds an external 1-bit full-subtractor LSB first,
// chains its borrow back in, and assembles the WIDTH-bit difference and final borrow.
module serial_sub_seq #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   serial_sub_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] aShift_q;
   logic [WIDTH-1:0] aShift_d;
   logic [WIDTH-1:0] bShift_q;
   logic [WIDTH-1:0] bShift_d;
   logic [WIDTH-2:0] dShift_q;
   logic [WIDTH-2:0] dShift_d;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_d;
   logic             borrow_q;
   logic             borrow_d;
   logic             borrowOut_q;
   logic             borrowOut_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   logic             lastBit;
   logic [WIDTH-1:0] dShiftWide;

   // The MSB difference bit never needs storing: it arrives on the final edge
   // and goes straight into diff together with the WIDTH-1 bits collected so far.
   assign lastBit    = (count_q == CW'(WIDTH - 1));
   assign dShiftWide = {bus.fs_d, dShift_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (lastBit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.fs_a   = 1'b0;
      bus.fs_b   = 1'b0;
      bus.fs_bin = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state_q)
         SHIFT: begin
            bus.fs_a   = aShift_q[0];
            bus.fs_b   = bShift_q[0];
            bus.fs_bin = borrow_q;
            bus.busy   = 1'b1;
         end
         DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

   // Datapath next-state; diff and borrow_out only change on the final bit so they
   // hold the previous result for the whole of a new operation.
   always_comb begin
      aShift_d    = aShift_q;
      bShift_d    = bShift_q;
      dShift_d    = dShift_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      borrowOut_d = borrowOut_q;
      count_d     = count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               aShift_d = bus.a;
               bShift_d = bus.b;
               borrow_d = bus.bin;
               count_d  = '0;
            end
         end
         SHIFT: begin
            aShift_d = {1'b0, aShift_q[WIDTH-1:1]};
            bShift_d = {1'b0, bShift_q[WIDTH-1:1]};
            dShift_d = dShiftWide[WIDTH-1:1];
            borrow_d = bus.fs_bout;
            count_d  = count_q + 1'b1;
            if (lastBit) begin
               diff_d      = dShiftWide;
               borrowOut_d = bus.fs_bout;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aShift_q    <= '0;
         bShift_q    <= '0;
         dShift_q    <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         borrowOut_q <= 1'b0;
         count_q     <= '0;
      end else begin
         aShift_q    <= aShift_d;
         bShift_q    <= bShift_d;
         dShift_q    <= dShift_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         borrowOut_q <= borrowOut_d;
         count_q     <= count_d;
      end
   end

   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrowOut_q;

endmodule
